// File: rtl/cp0_int_ctrl_if.sv
// Bus between the pipeline controller and the CP0 interrupt unit.
// id_valid qualifies int_type/pc_id/cp0_addr/cp0_wdata for one cycle; jump_en and
// return_en are one-cycle strobes qualifying redirect_pc; there is no ready, the
// consumer instead honours int_stall, which counts the cycles the unit is deaf.
interface cp0_int_ctrl_if;
  logic [1:0]  int_type;
  logic        id_valid;
  logic [31:0] pc_id;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        ext_int;
  logic [31:0] cp0_rdata;
  logic        jump_en;
  logic        return_en;
  logic [31:0] redirect_pc;
  logic [2:0]  int_stall;
  logic        ie;
  logic [31:0] epc;
  logic [1:0]  dbg_state;

  modport master (
    output int_type, id_valid, pc_id, cp0_addr, cp0_wdata, ext_int,
    input  cp0_rdata, jump_en, return_en, redirect_pc, int_stall, ie, epc, dbg_state
  );

  modport slave (
    input  int_type, id_valid, pc_id, cp0_addr, cp0_wdata, ext_int,
    output cp0_rdata, jump_en, return_en, redirect_pc, int_stall, ie, epc, dbg_state
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 STATUS/CAUSE/EPC with external-interrupt entry, eret return and a
// post-redirect blackout window.
module cp0_int_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
  parameter int unsigned BLACKOUT     = 3
) (
  input logic           clk,
  input logic           rst,
  cp0_int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_RETURN   = 2'd2,
    S_BLACKOUT = 2'd3
  } state_t;

  localparam logic [2:0] BLACKOUT_CNT = 3'(BLACKOUT);

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic        ie_q, ip_q;
  logic [31:0] epc_q;
  logic        sync1, sync2, sync3;

  logic accept, do_eret, do_int, do_mtc0, ext_rise;

  assign accept   = (state == S_IDLE) && bus.id_valid;
  assign do_eret  = accept && (bus.int_type == 2'b11);
  assign do_int   = accept && (bus.int_type == 2'b00) && ip_q && ie_q;
  assign do_mtc0  = bus.id_valid && (bus.int_type == 2'b10);
  assign ext_rise = sync2 && !sync3;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (do_eret)     state_next = S_RETURN;
        else if (do_int) state_next = S_REDIRECT;
      end
      S_REDIRECT, S_RETURN: state_next = S_BLACKOUT;
      S_BLACKOUT: if (cnt <= 3'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.jump_en     = 1'b0;
    bus.return_en   = 1'b0;
    bus.redirect_pc = 32'h0;
    case (state)
      S_REDIRECT: begin
        bus.jump_en     = 1'b1;
        bus.redirect_pc = HANDLER_ADDR;
      end
      S_RETURN: begin
        bus.return_en   = 1'b1;
        bus.redirect_pc = epc_q;
      end
      default: ;
    endcase
  end

  // Counter is loaded during the pulse cycle, so int_stall reads 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else begin
      case (state)
        S_REDIRECT, S_RETURN: cnt <= BLACKOUT_CNT;
        S_BLACKOUT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        default: cnt <= 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      ip_q  <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= 32'h0;
    end else begin
      sync1 <= bus.ext_int;
      sync2 <= sync1;
      sync3 <= sync2;
      // A fresh edge beats both the entry clear and an mtc0 clear.
      if (ext_rise)                              ip_q <= 1'b1;
      else if (do_int)                           ip_q <= 1'b0;
      else if (do_mtc0 && bus.cp0_addr == 5'd13) ip_q <= bus.cp0_wdata[10];
      if (do_int)                                ie_q <= 1'b0;
      else if (do_eret)                          ie_q <= 1'b1;
      else if (do_mtc0 && bus.cp0_addr == 5'd12) ie_q <= bus.cp0_wdata[0];
      if (do_int)                                epc_q <= bus.pc_id;
      else if (do_mtc0 && bus.cp0_addr == 5'd14) epc_q <= bus.cp0_wdata;
    end
  end

  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = {31'b0, ie_q};
      5'd13:   bus.cp0_rdata = {21'b0, ip_q, 10'b0};
      5'd14:   bus.cp0_rdata = epc_q;
      default: bus.cp0_rdata = 32'h0;
    endcase
  end

  assign bus.int_stall = cnt;
  assign bus.ie        = ie_q;
  assign bus.epc       = epc_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Vector-table bench for cp0_int_ctrl plus hand-written synchronizer corner cases.
module tb_cp0_int_ctrl;
  localparam logic [1:0]  N  = 2'b00;
  localparam logic [1:0]  MT = 2'b10;
  localparam logic [1:0]  ER = 2'b11;
  localparam logic [31:0] H  = 32'h0000_0004;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cp0_int_ctrl_if bus();

  cp0_int_ctrl #(.HANDLER_ADDR(H), .BLACKOUT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected vector: {state, jump_en, return_en, redirect_pc, int_stall, ie, epc, cp0_rdata}
  typedef struct {
    logic         rst;
    logic [1:0]   op;
    logic         valid;
    logic [31:0]  pc;
    logic [4:0]   addr;
    logic [31:0]  wdata;
    logic         ext;
    logic         chk;
    logic [103:0] exp;
  } vec_t;

  vec_t         tbl[$];
  logic [103:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] op, input logic v,
                              input logic [31:0] pc, input logic [4:0] a,
                              input logic [31:0] wd, input logic e, input logic c,
                              input logic je, input logic re, input logic [31:0] rpc,
                              input logic [2:0] st, input logic ie, input logic [31:0] epc,
                              input logic [31:0] rd);
    vec_t       t;
    logic [1:0] s;
    s = je ? 2'd1 : re ? 2'd2 : (st != 3'd0) ? 2'd3 : 2'd0;
    t.rst = r; t.op = op; t.valid = v; t.pc = pc; t.addr = a;
    t.wdata = wd; t.ext = e; t.chk = c;
    t.exp = {s, je, re, rpc, st, ie, epc, rd};
    return t;
  endfunction

  function automatic logic [103:0] actual();
    return {bus.dbg_state, bus.jump_en, bus.return_en, bus.redirect_pc,
            bus.int_stall, bus.ie, bus.epc, bus.cp0_rdata};
  endfunction

  task automatic check(input string name, input logic [103:0] act);
    logic [103:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic drive(input vec_t t);
    rst           = t.rst;
    bus.int_type  = t.op;
    bus.id_valid  = t.valid;
    bus.pc_id     = t.pc;
    bus.cp0_addr  = t.addr;
    bus.cp0_wdata = t.wdata;
    bus.ext_int   = t.ext;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.int_type = N; bus.id_valid = 1'b0; bus.pc_id = 32'h0;
    bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'h0; bus.ext_int = 1'b0;

    // reset
    tbl.push_back(mk(1, N, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, N, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, N, 0, 0, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, N, 0, 0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // interrupt entry: enable, raise ext_int, IP on 3rd edge, pulse, blackout
    tbl.push_back(mk(0, MT, 1, 0, 12, 1, 0, 1,        0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, N, 1, 32'h40, 12, 0, 1, 1,    0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 1, 1,    0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 1, 1,    0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 1, 1,    0, 0, 0, 0, 1, 0, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'h40, 14, 0, 0, 1,    1, 0, H, 0, 0, 32'h40, 32'h40));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 0, 1,    0, 0, 0, 3, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 0, 1,    0, 0, 0, 2, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h40, 13, 0, 0, 1,    0, 0, 0, 1, 0, 32'h40, 0));
    // masking: IE=0, pulse ext_int, IP pends, enable later
    tbl.push_back(mk(0, N, 1, 32'h80, 13, 0, 1, 1,    0, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h80, 13, 0, 1, 1,    0, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h80, 13, 0, 0, 1,    0, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h80, 13, 0, 0, 1,    0, 0, 0, 0, 0, 32'h40, 32'h400));
    tbl.push_back(mk(0, MT, 1, 32'h80, 12, 1, 0, 1,   0, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(0, N, 1, 32'h80, 12, 0, 0, 1,    0, 0, 0, 0, 1, 32'h40, 1));
    tbl.push_back(mk(0, N, 1, 32'h80, 14, 0, 0, 1,    1, 0, H, 0, 0, 32'h80, 32'h80));
    tbl.push_back(mk(0, N, 1, 32'h80, 14, 0, 0, 1,    0, 0, 0, 3, 0, 32'h80, 32'h80));
    tbl.push_back(mk(0, N, 1, 32'h80, 14, 0, 0, 1,    0, 0, 0, 2, 0, 32'h80, 32'h80));
    tbl.push_back(mk(0, N, 1, 32'h80, 14, 0, 0, 1,    0, 0, 0, 1, 0, 32'h80, 32'h80));
    // eret to EPC=0x40
    tbl.push_back(mk(0, MT, 1, 0, 14, 32'h40, 0, 1,   0, 0, 0, 0, 0, 32'h80, 32'h80));
    tbl.push_back(mk(0, ER, 1, 0, 14, 0, 0, 1,        0, 0, 0, 0, 0, 32'h40, 32'h40));
    tbl.push_back(mk(0, N, 1, 0, 12, 0, 0, 1,         0, 1, 32'h40, 0, 1, 32'h40, 1));
    tbl.push_back(mk(0, N, 1, 0, 12, 0, 0, 1,         0, 0, 0, 3, 1, 32'h40, 1));
    tbl.push_back(mk(0, N, 1, 0, 12, 0, 0, 1,         0, 0, 0, 2, 1, 32'h40, 1));
    tbl.push_back(mk(0, N, 1, 0, 12, 0, 0, 1,         0, 0, 0, 1, 1, 32'h40, 1));
    // eret wins over pending interrupt; interrupt taken after blackout
    tbl.push_back(mk(0, MT, 1, 0, 13, 32'h400, 0, 1,  0, 0, 0, 0, 1, 32'h40, 0));
    tbl.push_back(mk(0, ER, 1, 0, 13, 0, 0, 1,        0, 0, 0, 0, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'hC0, 13, 0, 0, 1,    0, 1, 32'h40, 0, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'hC0, 13, 0, 0, 1,    0, 0, 0, 3, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'hC0, 13, 0, 0, 1,    0, 0, 0, 2, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'hC0, 13, 0, 0, 1,    0, 0, 0, 1, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 1, 32'hC0, 13, 0, 0, 1,    0, 0, 0, 0, 1, 32'h40, 32'h400));
    tbl.push_back(mk(0, N, 0, 0, 14, 0, 0, 1,         1, 0, H, 0, 0, 32'hC0, 32'hC0));
    // mtc0 sets IP during blackout, then reset while int_stall=2
    tbl.push_back(mk(0, MT, 1, 0, 13, 32'h400, 0, 1,  0, 0, 0, 3, 0, 32'hC0, 0));
    tbl.push_back(mk(1, N, 0, 0, 13, 0, 0, 1,         0, 0, 0, 2, 0, 32'hC0, 32'h400));
    tbl.push_back(mk(0, N, 0, 0, 13, 0, 0, 1,         0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, N, 0, 0, 13, 0, 0, 1,         0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk) begin
        exp_q.push_back(tbl[i].exp);
        check($sformatf("vec%0d", i), actual());
      end
    end

    // edge on the same cycle as an mtc0 clearing IP
    @(negedge clk);
    bus.ext_int = 1'b1; bus.int_type = N; bus.id_valid = 1'b0; bus.cp0_addr = 5'd13;
    @(negedge clk);
    @(negedge clk);
    bus.int_type = MT; bus.id_valid = 1'b1; bus.cp0_wdata = 32'h0;
    @(negedge clk);
    bus.int_type = N; bus.id_valid = 1'b0;
    #1;
    exp_q.push_back(104'(32'h400));
    check("edge_beats_mtc0_clear", 104'(bus.cp0_rdata));

    // plain mtc0 clear, then a held level must not set IP again
    @(negedge clk);
    bus.int_type = MT; bus.id_valid = 1'b1; bus.cp0_wdata = 32'h0;
    @(negedge clk);
    bus.int_type = N; bus.id_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    exp_q.push_back(104'(32'h0));
    check("held_level_sets_once", 104'(bus.cp0_rdata));

    // a new rise sets IP again, exactly three edges later
    @(negedge clk);
    bus.ext_int = 1'b0;
    repeat (4) @(negedge clk);
    bus.ext_int = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      #1;
    end while (bus.cp0_rdata != 32'h400 && n < 10);
    exp_q.push_back(104'(3));
    check("rerise_latency", 104'(n));
    bus.ext_int = 1'b0;

    // masked with IE=0: no redirect despite pending IP and valid slot
    bus.id_valid = 1'b1; bus.int_type = N;
    @(negedge clk);
    @(negedge clk);
    #1;
    exp_q.push_back(104'(0));
    check("masked_no_jump", 104'({bus.jump_en, bus.dbg_state}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
